// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit holding the architectural HI/LO pair.
// One result bit per cycle; stalls upstream only for instructions that touch HI/LO.
module ex_muldiv_unit #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] DIV0_LO = {XLEN{1'b1}}
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic [2:0]      eop,
   input  logic            erdhl,
   input  logic [XLEN-1:0] ea,
   input  logic [XLEN-1:0] eb,
   output logic            estall,
   output logic            ebusy,
   output logic [XLEN-1:0] ehi,
   output logic [XLEN-1:0] elo
);

   localparam int            CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;
   logic [CW-1:0]        r_cnt;
   logic [2*XLEN-1:0]    r_acc;
   logic [XLEN-1:0]      r_opnd;
   logic [XLEN-1:0]      r_hi;
   logic [XLEN-1:0]      r_lo;
   logic                 r_isDiv;
   logic                 r_negRes;
   logic                 r_negRem;

   logic                 w_isMul;
   logic                 w_isDiv;
   logic                 w_signedOp;
   logic                 w_opNop;
   logic                 w_divZero;
   logic [XLEN-1:0]      w_absA;
   logic [XLEN-1:0]      w_absB;
   logic [XLEN:0]        w_mulSum;
   logic [2*XLEN-1:0]    w_mulNext;
   logic [XLEN:0]        w_divShift;
   logic [XLEN:0]        w_divDiff;
   logic [2*XLEN-1:0]    w_divNext;
   logic [2*XLEN-1:0]    w_prodNeg;
   logic [XLEN-1:0]      w_fixHi;
   logic [XLEN-1:0]      w_fixLo;

   assign w_isMul    = (eop == OP_MULT) || (eop == OP_MULTU);
   assign w_isDiv    = (eop == OP_DIV)  || (eop == OP_DIVU);
   assign w_signedOp = (eop == OP_MULT) || (eop == OP_DIV);
   assign w_opNop    = (eop == OP_NOP)  || (eop == OP_RSVD);
   assign w_divZero  = (eb == '0);
   assign w_absA     = (w_signedOp && ea[XLEN-1]) ? -ea : ea;
   assign w_absB     = (w_signedOp && eb[XLEN-1]) ? -eb : eb;

   // Shift-add: upper half accumulates the multiplicand, lower half holds the
   // remaining multiplier bits and fills with product bits as it shifts right.
   assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

   // Restoring divide: upper half is the partial remainder, lower half the
   // dividend shifting out as quotient bits shift in.
   assign w_divShift = r_acc[2*XLEN-1:XLEN-1];
   assign w_divDiff  = w_divShift - {1'b0, r_opnd};
   assign w_divNext  = {(w_divDiff[XLEN] ? w_divShift[XLEN-1:0] : w_divDiff[XLEN-1:0]),
                        r_acc[XLEN-2:0], ~w_divDiff[XLEN]};

   assign w_prodNeg = -r_acc;

   always_comb begin
      w_fixHi = r_acc[2*XLEN-1:XLEN];
      w_fixLo = r_acc[XLEN-1:0];
      if (r_isDiv) begin
         if (r_negRes) w_fixLo = -r_acc[XLEN-1:0];
         if (r_negRem) w_fixHi = -r_acc[2*XLEN-1:XLEN];
      end else if (r_negRes) begin
         w_fixHi = w_prodNeg[2*XLEN-1:XLEN];
         w_fixLo = w_prodNeg[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) r_state <= S_IDLE;
      else      r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      ebusy       = 1'b0;
      estall      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_isMul)      w_stateNext = S_MUL;
            else if (w_isDiv) w_stateNext = w_divZero ? S_FIX : S_DIV;
         end
         S_MUL:   if (r_cnt == LAST) w_stateNext = S_FIX;
         S_DIV:   if (r_cnt == LAST) w_stateNext = S_FIX;
         S_FIX:   w_stateNext = S_IDLE;
         default: w_stateNext = S_IDLE;
      endcase
      ebusy  = (r_state != S_IDLE);
      estall = ebusy & (~w_opNop | erdhl);
   end

   // Operand capture, iteration and HI/LO writeback; only latched copies are
   // used once an operation has been accepted.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_isDiv  <= 1'b0;
         r_negRes <= 1'b0;
         r_negRem <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_isMul) begin
                  r_acc    <= {{XLEN{1'b0}}, w_absB};
                  r_opnd   <= w_absA;
                  r_isDiv  <= 1'b0;
                  r_negRes <= w_signedOp & (ea[XLEN-1] ^ eb[XLEN-1]);
                  r_negRem <= 1'b0;
               end else if (w_isDiv) begin
                  r_isDiv <= 1'b1;
                  if (w_divZero) begin
                     r_acc    <= {ea, DIV0_LO};
                     r_opnd   <= '0;
                     r_negRes <= 1'b0;
                     r_negRem <= 1'b0;
                  end else begin
                     r_acc    <= {{XLEN{1'b0}}, w_absA};
                     r_opnd   <= w_absB;
                     r_negRes <= w_signedOp & (ea[XLEN-1] ^ eb[XLEN-1]);
                     r_negRem <= w_signedOp & ea[XLEN-1];
                  end
               end else if (eop == OP_MTHI) begin
                  r_hi <= ea;
               end else if (eop == OP_MTLO) begin
                  r_lo <= ea;
               end
            end
            S_MUL: begin
               r_acc <= w_mulNext;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DIV: begin
               r_acc <= w_divNext;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_hi <= w_fixHi;
               r_lo <= w_fixLo;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign ehi = r_hi;
   assign elo = r_lo;

endmodule
